clkdiv_cfg_ctrl: RTL and testbench

Configuration front-end that sits directly upstream of the programmable clock divider. It accepts a request through a valid/ready handshake: total period in input-clock cycles, duty cycle in percent, and start phase. It computes the divider's high_count, low_count and wait_count with a sequential restoring division, then presents them and pulses the divider reset so the new waveform starts cleanly from a known phase.

---
 rtl/clkdiv_pkg.sv | 25 ++
 rtl/clkdiv_seq_div.sv | 74 +++++++
 rtl/clkdiv_cfg_ctrl.sv | 143 ++++++++++++++
 tb/tb_clkdiv_cfg_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// Shared types and constants for the clock-divider configuration front-end.
// The duty arithmetic is done in percent with round-to-nearest before division.
package clkdiv_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

   localparam int DUTY_W   = 7;
   localparam int DUTY_DEN = 100;
   localparam int DUTY_RND = 50;
   localparam int DUTY_MAX = 99;
   localparam int DIV_MIN  = 2;

   // Product of a period and a 7-bit duty needs this many bits.
   function automatic int prod_w(input int div_w);
      return div_w + DUTY_W;
   endfunction

   localparam int DIV_W_DEF  = 32;
   localparam int PROD_W_DEF = DIV_W_DEF + DUTY_W;

endpackage

// File: rtl/clkdiv_seq_div.sv
// Restoring divider by the constant DUTY_DEN, one quotient bit per clock.
// start_i loads the dividend; done_o rises after exactly W iterations and stays high.
module clkdiv_seq_div
   import clkdiv_pkg::*;
#(
   parameter int W = PROD_W_DEF
) (
   input  logic         clk_i,
   input  logic         rst,
   input  logic         start_i,
   input  logic [W-1:0] dividend_i,
   output logic [W-1:0] quot_o,
   output logic         done_o
);

   localparam int CNT_W = $clog2(W + 1);

   logic [W-1:0]     work_q, work_d;
   logic [6:0]       rem_q, rem_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             run_q, run_d;
   logic             done_q, done_d;
   logic [7:0]       trial;

   // work_q shifts dividend bits out of the top and quotient bits in at the bottom.
   always_comb begin
      work_d = work_q;
      rem_d  = rem_q;
      cnt_d  = cnt_q;
      run_d  = run_q;
      done_d = done_q;
      trial  = {rem_q, work_q[W-1]};
      if (start_i) begin
         work_d = dividend_i;
         rem_d  = 7'd0;
         cnt_d  = '0;
         run_d  = 1'b1;
         done_d = 1'b0;
      end else if (run_q) begin
         if (trial >= 8'(DUTY_DEN)) begin
            rem_d  = 7'(trial - 8'(DUTY_DEN));
            work_d = {work_q[W-2:0], 1'b1};
         end else begin
            rem_d  = trial[6:0];
            work_d = {work_q[W-2:0], 1'b0};
         end
         cnt_d = cnt_q + CNT_W'(1);
         if (cnt_q == CNT_W'(W - 1)) begin
            run_d  = 1'b0;
            done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst) begin
      if (rst) begin
         work_q <= '0;
         rem_q  <= 7'd0;
         cnt_q  <= '0;
         run_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         work_q <= work_d;
         rem_q  <= rem_d;
         cnt_q  <= cnt_d;
         run_q  <= run_d;
         done_q <= done_d;
      end
   end

   assign quot_o = work_q;
   assign done_o = done_q;

endmodule

// File: rtl/clkdiv_cfg_ctrl.sv
// Converts period/duty/phase requests into divider high/low/wait counts and
// pulses the divider reset so the new waveform starts from a known phase.
module clkdiv_cfg_ctrl
   import clkdiv_pkg::*;
#(
   parameter int DIV_W      = 32,
   parameter int RST_CYCLES = 2
) (
   input  logic             clk_i,
   input  logic             rst,
   // Handshake: a request transfers on a rising edge with cfg_valid_i && cfg_ready_o;
   // the requester holds valid and data stable until then, nothing is queued.
   input  logic             cfg_valid_i,
   output logic             cfg_ready_o,
   input  logic [DIV_W-1:0] div_i,
   input  logic [6:0]       duty_pct_i,
   input  logic [DIV_W-1:0] phase_i,
   output logic [DIV_W-1:0] high_count_o,
   output logic [DIV_W-1:0] low_count_o,
   output logic [DIV_W-1:0] wait_count_o,
   output logic             div_rst_o,
   output logic             busy_o,
   output logic             err_o,
   output state_e           dbg_state_o
);

   localparam int PROD_W = prod_w(DIV_W);
   localparam int HC_W   = $clog2(RST_CYCLES) + 1;

   state_e           state_q, state_d;
   logic [HC_W-1:0]  hold_q, hold_d;
   logic [DIV_W-1:0] high_q, high_d, low_q, low_d, wait_q, wait_d;
   logic [DIV_W-1:0] div_val_q, div_val_d, phase_q, phase_d;
   logic             div_rst_q, div_rst_d, err_q, err_d;

   logic              handshake, illegal, div_start, div_done;
   logic [PROD_W-1:0] product, quot;
   logic [DIV_W-1:0]  h_calc, l_calc, w_calc;

   assign handshake = cfg_valid_i && (state_q == ST_IDLE);
   assign illegal   = (div_i < DIV_W'(DIV_MIN)) || (duty_pct_i == 7'd0) ||
                      (duty_pct_i > 7'(DUTY_MAX));
   assign div_start = handshake && !illegal;
   assign product   = PROD_W'(div_i) * PROD_W'(duty_pct_i) + PROD_W'(DUTY_RND);

   clkdiv_seq_div #(.W(PROD_W)) u_div (
      .clk_i      (clk_i),
      .rst        (rst),
      .start_i    (div_start),
      .dividend_i (product),
      .quot_o     (quot),
      .done_o     (div_done)
   );

   // Both halves of the period must be at least one cycle long.
   always_comb begin
      if (quot == '0)
         h_calc = DIV_W'(1);
      else if (quot >= PROD_W'(div_val_q))
         h_calc = div_val_q - DIV_W'(1);
      else
         h_calc = quot[DIV_W-1:0];
      l_calc = div_val_q - h_calc;
      w_calc = (&phase_q) ? phase_q : phase_q + DIV_W'(1);
   end

   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      high_d    = high_q;
      low_d     = low_q;
      wait_d    = wait_q;
      div_val_d = div_val_q;
      phase_d   = phase_q;
      div_rst_d = div_rst_q;
      err_d     = err_q;
      case (state_q)
         ST_IDLE: begin
            if (handshake) begin
               err_d = illegal;
               if (!illegal) begin
                  div_val_d = div_i;
                  phase_d   = phase_i;
                  state_d   = ST_CALC;
               end
            end
         end
         ST_CALC: begin
            if (div_done) begin
               high_d    = h_calc;
               low_d     = l_calc;
               wait_d    = w_calc;
               div_rst_d = 1'b1;
               hold_d    = '0;
               state_d   = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (hold_q == HC_W'(RST_CYCLES - 1)) begin
               div_rst_d = 1'b0;
               state_d   = ST_IDLE;
            end else begin
               hold_d = hold_q + HC_W'(1);
            end
         end
         default: state_d = ST_HOLD;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst) begin
      if (rst) begin
         state_q   <= ST_HOLD;
         hold_q    <= '0;
         high_q    <= DIV_W'(1);
         low_q     <= DIV_W'(1);
         wait_q    <= DIV_W'(1);
         div_val_q <= '0;
         phase_q   <= '0;
         div_rst_q <= 1'b1;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         high_q    <= high_d;
         low_q     <= low_d;
         wait_q    <= wait_d;
         div_val_q <= div_val_d;
         phase_q   <= phase_d;
         div_rst_q <= div_rst_d;
         err_q     <= err_d;
      end
   end

   assign cfg_ready_o  = (state_q == ST_IDLE);
   assign busy_o       = (state_q != ST_IDLE);
   assign high_count_o = high_q;
   assign low_count_o  = low_q;
   assign wait_count_o = wait_q;
   assign div_rst_o    = div_rst_q;
   assign err_o        = err_q;
   assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_clkdiv_cfg_ctrl.sv
// Bench for clkdiv_cfg_ctrl: scenario tasks with an expected-count queue,
// reference counts derived from the arithmetic definition of the mapping.
module tb_clkdiv_cfg_ctrl;
   import clkdiv_pkg::*;

   localparam int DIV_W      = 32;
   localparam int RST_CYCLES = 2;
   localparam int CALC_LAT   = 40;
   localparam logic [DIV_W-1:0] ONES = '1;

   logic             clk_i = 1'b0;
   logic             rst = 1'b1;
   logic             cfg_valid_i = 1'b0;
   logic [DIV_W-1:0] div_i = '0;
   logic [6:0]       duty_pct_i = '0;
   logic [DIV_W-1:0] phase_i = '0;
   logic             cfg_ready_o, div_rst_o, busy_o, err_o;
   logic [DIV_W-1:0] high_count_o, low_count_o, wait_count_o;
   state_e           dbg_state_o;

   int checks = 0;
   int passed = 0;
   logic [3*DIV_W-1:0] exp_q[$];
   logic [3*DIV_W-1:0] cur_cnt = {32'd1, 32'd1, 32'd1};

   clkdiv_cfg_ctrl #(.DIV_W(DIV_W), .RST_CYCLES(RST_CYCLES)) dut (
      .clk_i        (clk_i),
      .rst          (rst),
      .cfg_valid_i  (cfg_valid_i),
      .cfg_ready_o  (cfg_ready_o),
      .div_i        (div_i),
      .duty_pct_i   (duty_pct_i),
      .phase_i      (phase_i),
      .high_count_o (high_count_o),
      .low_count_o  (low_count_o),
      .wait_count_o (wait_count_o),
      .div_rst_o    (div_rst_o),
      .busy_o       (busy_o),
      .err_o        (err_o),
      .dbg_state_o  (dbg_state_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [3*DIV_W-1:0] model(input logic [DIV_W-1:0] d,
                                                input logic [6:0] duty,
                                                input logic [DIV_W-1:0] ph);
      logic [63:0] n, q;
      logic [DIV_W-1:0] h, l, w;
      n = 64'(d) * 64'(duty) + 64'd50;
      q = n / 64'd100;
      if (q == 64'd0) h = 32'd1;
      else if (q >= 64'(d)) h = d - 32'd1;
      else h = q[DIV_W-1:0];
      l = d - h;
      w = (ph == ONES) ? ph : ph + 32'd1;
      return {h, l, w};
   endfunction

   task automatic wait_ready(input string tag);
      int n = 0;
      while (!cfg_ready_o && n < 200) begin
         @(negedge clk_i);
         n++;
      end
      checks++;
      if (cfg_ready_o !== 1'b1) $display("FAIL %s_ready_timeout: ready=%b required 1", tag, cfg_ready_o);
      else passed++;
   endtask

   task automatic release_seq(input string tag);
      for (int i = 0; i < RST_CYCLES; i++) begin
         @(negedge clk_i);
         checks++;
         if ({div_rst_o, cfg_ready_o} !== ((i == RST_CYCLES - 1) ? 2'b01 : 2'b10))
            $display("FAIL %s_hold%0d: div_rst/ready=%b%b", tag, i, div_rst_o, cfg_ready_o);
         else passed++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk_i);
      checks++;
      if ({high_count_o, low_count_o, wait_count_o} !== {32'd1, 32'd1, 32'd1})
         $display("FAIL reset_counts: got %h/%h/%h required 1/1/1", high_count_o, low_count_o, wait_count_o);
      else passed++;
      checks++;
      if ({div_rst_o, cfg_ready_o, busy_o, err_o} !== 4'b1010)
         $display("FAIL reset_flags: div_rst/ready/busy/err=%b%b%b%b required 1010",
                  div_rst_o, cfg_ready_o, busy_o, err_o);
      else passed++;
      rst = 1'b0;
      release_seq("reset");
   endtask

   task automatic run_legal(input logic [DIV_W-1:0] d, input logic [6:0] duty,
                            input logic [DIV_W-1:0] ph);
      logic [3*DIV_W-1:0] exp_v;
      int cyc;
      exp_q.push_back(model(d, duty, ph));
      wait_ready("legal");
      cfg_valid_i = 1'b1; div_i = d; duty_pct_i = duty; phase_i = ph;
      @(negedge clk_i);
      cfg_valid_i = 1'b0;
      cyc = 0;
      checks++;
      if ({busy_o, cfg_ready_o, err_o} !== 3'b100)
         $display("FAIL accept_d%0d: busy/ready/err=%b%b%b required 100", d, busy_o, cfg_ready_o, err_o);
      else passed++;
      while (!div_rst_o && cyc < CALC_LAT + 20) begin
         @(negedge clk_i);
         cyc++;
         if (cyc == 20) begin
            checks++;
            if ({high_count_o, low_count_o, wait_count_o, dbg_state_o} !== {cur_cnt, ST_CALC})
               $display("FAIL calc_stable_d%0d: got %h/%h/%h st=%0d", d,
                        high_count_o, low_count_o, wait_count_o, dbg_state_o);
            else passed++;
         end
      end
      checks++;
      if (cyc != CALC_LAT) $display("FAIL latency_d%0d: got %0d required %0d", d, cyc, CALC_LAT);
      else passed++;
      exp_v = exp_q.pop_front();
      checks++;
      if ({high_count_o, low_count_o, wait_count_o} !== exp_v)
         $display("FAIL counts_d%0d_duty%0d: got %0d/%0d/%0d required %0d/%0d/%0d", d, duty,
                  high_count_o, low_count_o, wait_count_o,
                  exp_v[95:64], exp_v[63:32], exp_v[31:0]);
      else passed++;
      cur_cnt = exp_v;
      release_seq("apply");
   endtask

   task automatic test_illegal(input logic [DIV_W-1:0] d, input logic [6:0] duty);
      logic pulse = 1'b0;
      wait_ready("illegal");
      cfg_valid_i = 1'b1; div_i = d; duty_pct_i = duty; phase_i = 32'd3;
      @(negedge clk_i);
      cfg_valid_i = 1'b0;
      checks++;
      if ({err_o, cfg_ready_o, div_rst_o} !== 3'b110)
         $display("FAIL illegal_d%0d_duty%0d: err/ready/div_rst=%b%b%b required 110",
                  d, duty, err_o, cfg_ready_o, div_rst_o);
      else passed++;
      repeat (4) begin
         @(negedge clk_i);
         pulse |= div_rst_o;
      end
      checks++;
      if ({pulse, high_count_o, low_count_o, wait_count_o} !== {1'b0, cur_cnt})
         $display("FAIL illegal_quiet_d%0d: pulse=%b counts=%h/%h/%h", d, pulse,
                  high_count_o, low_count_o, wait_count_o);
      else passed++;
   endtask

   task automatic test_rst_mid_calc();
      wait_ready("rstcalc");
      cfg_valid_i = 1'b1; div_i = 32'd12; duty_pct_i = 7'd25; phase_i = 32'd9;
      @(negedge clk_i);
      cfg_valid_i = 1'b0;
      repeat (20) @(negedge clk_i);
      rst = 1'b1;
      #1;
      checks++;
      if ({high_count_o, low_count_o, wait_count_o, div_rst_o, cfg_ready_o, busy_o} !==
          {32'd1, 32'd1, 32'd1, 3'b101})
         $display("FAIL rst_mid_calc: counts=%h/%h/%h div_rst/ready/busy=%b%b%b",
                  high_count_o, low_count_o, wait_count_o, div_rst_o, cfg_ready_o, busy_o);
      else passed++;
      cur_cnt = {32'd1, 32'd1, 32'd1};
      @(negedge clk_i);
      rst = 1'b0;
      release_seq("rstcalc");
   endtask

   task automatic test_back_to_back();
      logic [3*DIV_W-1:0] exp_v;
      int cyc = 0;
      exp_q.push_back(model(32'd20, 7'd30, 32'd0));
      exp_q.push_back(model(32'd9, 7'd60, 32'd2));
      wait_ready("b2b");
      cfg_valid_i = 1'b1; div_i = 32'd20; duty_pct_i = 7'd30; phase_i = 32'd0;
      @(negedge clk_i);
      cfg_valid_i = 1'b0;
      while (!div_rst_o && cyc < CALC_LAT + 20) begin
         @(negedge clk_i);
         cyc++;
      end
      exp_v = exp_q.pop_front();
      checks++;
      if ({high_count_o, low_count_o, wait_count_o} !== exp_v || cyc != CALC_LAT)
         $display("FAIL b2b_first: got %0d/%0d/%0d at %0d required %0d/%0d/%0d at %0d",
                  high_count_o, low_count_o, wait_count_o, cyc,
                  exp_v[95:64], exp_v[63:32], exp_v[31:0], CALC_LAT);
      else passed++;
      // Second request is held while the block is still in HOLD.
      cfg_valid_i = 1'b1; div_i = 32'd9; duty_pct_i = 7'd60; phase_i = 32'd2;
      while (!cfg_ready_o && cyc < CALC_LAT + 20) begin
         @(negedge clk_i);
         cyc++;
      end
      @(negedge clk_i);
      cyc++;
      cfg_valid_i = 1'b0;
      while (!div_rst_o && cyc < 2 * CALC_LAT + 20) begin
         @(negedge clk_i);
         cyc++;
      end
      exp_v = exp_q.pop_front();
      checks++;
      if ({high_count_o, low_count_o, wait_count_o} !== exp_v ||
          cyc != 2 * CALC_LAT + RST_CYCLES + 1)
         $display("FAIL b2b_second: got %0d/%0d/%0d at %0d required %0d/%0d/%0d at %0d",
                  high_count_o, low_count_o, wait_count_o, cyc,
                  exp_v[95:64], exp_v[63:32], exp_v[31:0], 2 * CALC_LAT + RST_CYCLES + 1);
      else passed++;
      cur_cnt = exp_v;
      release_seq("b2b");
   endtask

   initial begin
      test_reset();
      run_legal(32'd10, 7'd50, 32'd0);
      run_legal(32'd3, 7'd50, 32'd0);
      run_legal(32'd2, 7'd1, 32'd0);
      run_legal(32'd7, 7'd99, 32'd0);
      test_illegal(32'd1, 7'd50);
      test_illegal(32'd10, 7'd0);
      test_illegal(32'd10, 7'd100);
      test_illegal(32'd0, 7'd127);
      run_legal(32'd10, 7'd50, 32'd4);
      run_legal(32'd100, 7'd33, ONES);
      run_legal(ONES, 7'd99, 32'd17);
      for (int i = 0; i < 4; i++)
         run_legal(32'($urandom_range(2, 5000)), 7'($urandom_range(1, 99)),
                   32'($urandom_range(0, 1000)));
      test_rst_mid_calc();
      run_legal(32'd10, 7'd50, 32'd4);
      test_back_to_back();
      checks++;
      if (exp_q.size() != 0) $display("FAIL queue_empty: %0d entries left", exp_q.size());
      else passed++;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
